// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for the multicycle RISC-V control FSM. Holds a
// unified instruction/data word memory and answers one word request at a
// time over valid/ready request and response channels, inserting
// WAIT_CYCLES wait states between request acceptance and response.
//
// Optional build macro: MEM_ALIGN_CHECK_EN
//   defined   - misaligned reads and writes whose byte enables do not fit
//               the address offset return rsp_err = 1 with no memory update
//   undefined - addr[1:0] is ignored and no alignment error is raised
module mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
    localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0]  CNT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    // Latched request, used for the commit when the access goes through WAIT
    logic        q_we;
    logic [31:0] q_addr;
    logic [31:0] q_wdata;
    logic [3:0]  q_be;

    // NOTE: the word array has no reset; its contents are undefined until
    // written, which keeps it mappable onto plain RAM.
    logic [31:0] mem [DEPTH_WORDS];

    // Commit-side view of the request: with no wait states the commit
    // happens on the acceptance edge, so the live inputs must be used.
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_be;
    logic [31:0] c_off;
    logic [IDX_W-1:0] c_idx;
    logic        c_in_range;
    logic        c_align_err;
    logic        c_err;
    logic        commit;
    logic        accept;
    logic        mem_we;
    logic [31:0] rd_word;
    logic [31:0] commit_rdata;

`ifdef MEM_ALIGN_CHECK_EN
    // Legal byte-enable patterns for a write at a given byte offset
    function automatic logic align_bad(input logic we, input logic [1:0] off,
                                       input logic [3:0] be);
        logic bad;
        bad = 1'b1;
        if (!we) begin
            bad = (off != 2'd0);
        end else begin
            case (be)
                4'b0000: bad = 1'b0;
                4'b1111: bad = (off != 2'd0);
                4'b0011: bad = (off != 2'd0);
                4'b1100: bad = (off != 2'd2);
                4'b0001, 4'b0010, 4'b0100, 4'b1000:
                         bad = (be != (4'b0001 << off));
                default: bad = 1'b1;
            endcase
        end
        return bad;
    endfunction
`endif

    // Select the request fields that feed this cycle's commit
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        c_we    = q_we;
        c_addr  = q_addr;
        c_wdata = q_wdata;
        c_be    = q_be;
        if (state == IDLE) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_be    = req_be;
        end
    end

    assign accept     = (state == IDLE) && req_valid && req_ready;
    assign commit     = (accept && NO_WAIT) || ((state == WAIT) && (cnt == 4'd0));

    // Address decode; subtraction wraps modulo 2^32 so addresses below the
    // base land far out of range.
    assign c_off      = c_addr - BASE_ADDR;
    assign c_idx      = c_off[IDX_W+1:2];
    assign c_in_range = ({1'b0, c_off} < SPAN);

`ifdef MEM_ALIGN_CHECK_EN
    assign c_align_err = align_bad(c_we, c_off[1:0], c_be);
`else
    assign c_align_err = 1'b0;
`endif

    assign c_err   = !c_in_range || c_align_err;
    assign mem_we  = commit && c_we && !c_err;
    assign rd_word = mem[c_idx];

    assign commit_rdata = (c_we || c_err) ? 32'h0 : rd_word;

    // Only bits inside the array window take part in the decode
    logic unused_off;
    assign unused_off = &{1'b0, c_off[1:0], c_off[31:IDX_W+2]};

    // Byte-masked memory write on commit
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) begin
                    mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            q_we      <= 1'b0;
            q_addr    <= 32'h0;
            q_wdata   <= 32'h0;
            q_be      <= 4'h0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // right-hand side sees the values from before this edge.
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        q_we      <= req_we;
                        q_addr    <= req_addr;
                        q_wdata   <= req_wdata;
                        q_be      <= req_be;
                        req_ready <= 1'b0;
                        if (NO_WAIT) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= commit_rdata;
                            rsp_err   <= c_err;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    req_ready <= 1'b0;
                    if (cnt == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= commit_rdata;
                        rsp_err   <= c_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: a table of directed transactions with
// hand-computed responses, plus sequences for backpressure and reset.
module tb_mem_responder;

    localparam int W = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_vec = 0;
    int n_bad = 0;

    mem_responder #(
        .DEPTH_WORDS(1024),
        .WAIT_CYCLES(W),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input string name, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.name = name; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    // One full transaction: present request, wait for the response, hold
    // rsp_ready low for 'hold' cycles, then complete the handshake.
    task automatic txn(input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int guard;
        int lat;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check({name, "/req_ready_timeout"}, 32'(req_ready), 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (lat == 1) check({name, "/req_ready_busy"}, 32'(req_ready), 32'd0);
        end while (!rsp_valid && lat < 50);
        if (!rsp_valid) begin
            check({name, "/rsp_timeout"}, 32'(rsp_valid), 32'd1);
            return;
        end
        check({name, "/latency"}, 32'(lat), 32'(W + 1));
        check({name, "/rdata"}, rsp_rdata, exp_rdata);
        check({name, "/err"}, 32'(rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "/hold_valid"}, 32'(rsp_valid), 32'd1);
            check({name, "/hold_rdata"}, rsp_rdata, exp_rdata);
            check({name, "/hold_err"}, 32'(rsp_err), 32'(exp_err));
            check({name, "/hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, "/done_valid"}, 32'(rsp_valid), 32'd0);
        check({name, "/done_req_ready"}, 32'(req_ready), 32'd1);
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    localparam logic [31:0] WORD40 = 32'hCAFE_F00D;
`else
    localparam logic [31:0] WORD40 = 32'h0BAD_F00D;
`endif

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_be    = 4'h0;
        rsp_ready = 1'b0;

        add("wr_10",      1'b1, 32'h10,   32'hDEAD_BEEF, 4'b1111, 32'h0,         1'b0);
        add("rd_10",      1'b0, 32'h10,   32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0);
        add("wr_20",      1'b1, 32'h20,   32'h1122_3344, 4'b1111, 32'h0,         1'b0);
        add("wr_20_be",   1'b1, 32'h20,   32'hAABB_CCDD, 4'b0101, 32'h0,         1'b0);
        add("rd_20",      1'b0, 32'h20,   32'h0,         4'b0000, 32'h11BB_33DD, 1'b0);
        add("wr_0",       1'b1, 32'h0,    32'h0102_0304, 4'b1111, 32'h0,         1'b0);
        add("rd_oob",     1'b0, 32'h1000, 32'h0,         4'b0000, 32'h0,         1'b1);
        add("wr_oob",     1'b1, 32'h1000, 32'h5555_5555, 4'b1111, 32'h0,         1'b1);
        add("rd_0",       1'b0, 32'h0,    32'h0,         4'b0000, 32'h0102_0304, 1'b0);
        add("wr_30",      1'b1, 32'h30,   32'h1234_5678, 4'b1111, 32'h0,         1'b0);
        add("wr_30_be0",  1'b1, 32'h30,   32'hFFFF_FFFF, 4'b0000, 32'h0,         1'b0);
        add("rd_30",      1'b0, 32'h30,   32'h0,         4'b0000, 32'h1234_5678, 1'b0);
        add("wr_last",    1'b1, 32'hFFC,  32'h7777_8888, 4'b1111, 32'h0,         1'b0);
        add("rd_last",    1'b0, 32'hFFC,  32'h0,         4'b0000, 32'h7777_8888, 1'b0);
        add("wr_40",      1'b1, 32'h40,   32'h0BAD_F00D, 4'b1111, 32'h0,         1'b0);
`ifdef MEM_ALIGN_CHECK_EN
        add("rd_42",      1'b0, 32'h42,   32'h0,         4'b0000, 32'h0,         1'b1);
        add("wr_42_hi",   1'b1, 32'h42,   32'hCAFE_0000, 4'b1100, 32'h0,         1'b0);
        add("rd_40",      1'b0, 32'h40,   32'h0,         4'b0000, 32'hCAFE_F00D, 1'b0);
`else
        add("rd_42",      1'b0, 32'h42,   32'h0,         4'b0000, 32'h0BAD_F00D, 1'b0);
`endif
        add("rd_10_again", 1'b0, 32'h10,  32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0);

        // Reset values while rst_n is low
        #12;
        check("reset/req_ready", 32'(req_ready), 32'd0);
        check("reset/rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset/rsp_rdata", rsp_rdata, 32'h0);
        check("reset/rsp_err",   32'(rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset/req_ready_after", 32'(req_ready), 32'd1);

        foreach (vecs[i]) begin
            txn(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                vecs[i].exp_rdata, vecs[i].exp_err, 0);
        end

        // Response backpressure: five cycles with rsp_ready low
        txn("backpressure", 1'b0, 32'h20, 32'h0, 4'b0000, 32'h11BB_33DD, 1'b0, 5);

        // Reset while a write sits in WAIT: the write must be dropped
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'hCAFE_F00D;
        req_be    = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midreset/rsp_valid", 32'(rsp_valid), 32'd0);
        check("midreset/req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("midreset/rsp_valid_held", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midreset/no_response", 32'(rsp_valid), 32'd0);
        end
        txn("midreset/rd_40", 1'b0, 32'h40, 32'h0, 4'b0000, WORD40, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
